// File: rtl/des_pkg.sv
// Shared DES definitions: permutation tables, shift schedule, widths and
// the key-schedule state encoding, plus 28-bit half rotations.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Table entries use the standard 1-based bit numbering (bit 1 = MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Index 0 is round 1.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x,
                                             input logic [1:0] n);
    return (n == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]}
                       : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x,
                                             input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[CD_W-1:2]}
                       : {x[0], x[CD_W-1:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Pure combinational DES Permuted Choice 2: 56-bit {C,D} to 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0]   cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      subkey[SUBKEY_W-1-i] = cd[2*CD_W - PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads a key, then emits 16 subkeys in
// encrypt (K1..K16) or decrypt (K16..K1) order over a valid/ready port.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY_W-1:0]    key,
  output logic                ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                last,
  output logic                parity_err,
  output state_t              fsm_state
);

  // Handshake: a subkey transfers on every rising edge where
  // subkey_valid && subkey_ready. subkey_valid never depends on
  // subkey_ready, and subkey/round_idx/last hold until the transfer.

  state_t          state, state_n;
  logic [CD_W-1:0] c, c_n, d, d_n;
  logic [3:0]      cnt, cnt_n;
  logic            mode, mode_n;
  logic            perr_n;
  logic [2*CD_W-1:0] cd0;
  logic            key_even;

  always_comb begin
    cd0 = '0;
    for (int i = 0; i < 2*CD_W; i++) begin
      cd0[2*CD_W-1-i] = key[KEY_W - PC1[i]];
    end
  end

  always_comb begin
    key_even = 1'b0;
    for (int b = 0; b < KEY_W/8; b++) begin
      key_even = key_even | ~(^key[8*b +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      c          <= '0;
      d          <= '0;
      cnt        <= '0;
      mode       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      c          <= c_n;
      d          <= d_n;
      cnt        <= cnt_n;
      mode       <= mode_n;
      parity_err <= perr_n;
    end
  end

  always_comb begin
    state_n = state;
    c_n     = c;
    d_n     = d;
    cnt_n   = cnt;
    mode_n  = mode;
    perr_n  = parity_err;
    case (state)
      IDLE: begin
        if (start) begin
          // A total left shift of 28 is the identity, so decrypt starts at K16.
          if (decrypt) begin
            c_n = cd0[2*CD_W-1:CD_W];
            d_n = cd0[CD_W-1:0];
          end else begin
            c_n = rotl28(cd0[2*CD_W-1:CD_W], 2'd1);
            d_n = rotl28(cd0[CD_W-1:0], 2'd1);
          end
          cnt_n   = '0;
          mode_n  = decrypt;
          perr_n  = CHECK_PARITY && key_even;
          state_n = RUN;
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (cnt == 4'd15) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + 4'd1;
            if (mode) begin
              c_n = rotr28(c, SHIFT[4'd15 - cnt]);
              d_n = rotr28(d, SHIFT[4'd15 - cnt]);
            end else begin
              c_n = rotl28(c, SHIFT[cnt + 4'd1]);
              d_n = rotl28(d, SHIFT[cnt + 4'd1]);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ready        = (state == IDLE);
  assign subkey_valid = (state == RUN);
  assign round_idx    = cnt;
  assign last         = (state == RUN) && (cnt == 4'd15);
  assign fsm_state    = state;

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1
// key, with a parity-checking instance alongside the default one.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] key = '0;
  logic        subkey_ready = 1'b1;

  logic        ready0, valid0, last0, perr0;
  logic [47:0] subkey0;
  logic [3:0]  idx0;
  des_pkg::state_t st0;

  logic        ready1, valid1, last1, perr1;
  logic [47:0] subkey1;
  logic [3:0]  idx1;
  des_pkg::state_t st1;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_Z   = 64'h0101010101010101;

  logic [47:0] enc_k [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule #(.CHECK_PARITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
    .ready(ready0), .subkey(subkey0), .subkey_valid(valid0),
    .subkey_ready(subkey_ready), .round_idx(idx0), .last(last0),
    .parity_err(perr0), .fsm_state(st0)
  );

  des_key_schedule #(.CHECK_PARITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key(key),
    .ready(ready1), .subkey(subkey1), .subkey_valid(valid1),
    .subkey_ready(subkey_ready), .round_idx(idx1), .last(last1),
    .parity_err(perr1), .fsm_state(st1)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic start_schedule(input logic [63:0] k, input logic dec);
    key     = k;
    decrypt = dec;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    subkey_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid0); end
    checks++; if (subkey0 !== 48'h0) begin errors++; $display("FAIL reset_subkey: got %h expected 0", subkey0); end
    checks++; if (idx0 !== 4'd0) begin errors++; $display("FAIL reset_round_idx: got %0d expected 0", idx0); end
    checks++; if (last0 !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last0); end
    checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", perr1); end
  endtask

  task automatic test_encrypt();
    start_schedule(KEY_A, 1'b0);
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL enc_ready_in_run: got %b expected 0", ready0); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL enc_valid[%0d]: got %b expected 1", i, valid0); end
      checks++; if (subkey0 !== enc_k[i]) begin errors++; $display("FAIL enc_subkey[%0d]: got %h expected %h", i, subkey0, enc_k[i]); end
      checks++; if (idx0 !== 4'(i)) begin errors++; $display("FAIL enc_round_idx[%0d]: got %0d expected %0d", i, idx0, i); end
      checks++; if (last0 !== (i == 15)) begin errors++; $display("FAIL enc_last[%0d]: got %b expected %b", i, last0, (i == 15)); end
      step();
    end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL enc_ready_after: got %b expected 1", ready0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL enc_valid_after: got %b expected 0", valid0); end
  endtask

  // Starts in the very cycle ready returns, straight after test_encrypt.
  task automatic test_decrypt();
    start_schedule(KEY_A, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d]: got %b expected 1", i, valid0); end
      checks++; if (subkey0 !== enc_k[15-i]) begin errors++; $display("FAIL dec_subkey[%0d]: got %h expected %h", i, subkey0, enc_k[15-i]); end
      checks++; if (idx0 !== 4'(i)) begin errors++; $display("FAIL dec_round_idx[%0d]: got %0d expected %0d", i, idx0, i); end
      checks++; if (last0 !== (i == 15)) begin errors++; $display("FAIL dec_last[%0d]: got %b expected %b", i, last0, (i == 15)); end
      step();
    end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL dec_ready_after: got %b expected 1", ready0); end
  endtask

  task automatic test_back_to_back();
    start_schedule(KEY_A, 1'b0);
    for (int i = 0; i < 16; i++) step();
    start_schedule(KEY_A, 1'b1);
    checks++; if (subkey0 !== enc_k[15]) begin errors++; $display("FAIL b2b_first: got %h expected %h", subkey0, enc_k[15]); end
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", valid0); end
    for (int i = 0; i < 16; i++) step();
  endtask

  task automatic test_backpressure();
    start_schedule(KEY_A, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (subkey0 !== enc_k[i]) begin errors++; $display("FAIL bp_subkey[%0d]: got %h expected %h", i, subkey0, enc_k[i]); end
      checks++; if (idx0 !== 4'(i)) begin errors++; $display("FAIL bp_round_idx[%0d]: got %0d expected %0d", i, idx0, i); end
      if (i == 3) begin
        subkey_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          start = (s == 2);
          key = 64'h0;
          decrypt = 1'b1;
          step();
          start = 1'b0;
          checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d]: got %b expected 1", s, valid0); end
          checks++; if (subkey0 !== enc_k[3]) begin errors++; $display("FAIL bp_stall_subkey[%0d]: got %h expected %h", s, subkey0, enc_k[3]); end
          checks++; if (idx0 !== 4'd3) begin errors++; $display("FAIL bp_stall_round_idx[%0d]: got %0d expected 3", s, idx0); end
          checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", s, ready0); end
        end
        subkey_ready = 1'b1;
      end
      step();
    end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", ready0); end
  endtask

  task automatic test_reset_mid_run();
    start_schedule(KEY_A, 1'b0);
    for (int i = 0; i < 7; i++) step();
    checks++; if (idx0 !== 4'd7) begin errors++; $display("FAIL mid_round_idx: got %0d expected 7", idx0); end
    checks++; if (subkey0 !== enc_k[7]) begin errors++; $display("FAIL mid_subkey: got %h expected %h", subkey0, enc_k[7]); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", valid0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", ready0); end
    checks++; if (subkey0 !== 48'h0) begin errors++; $display("FAIL mid_rst_subkey: got %h expected 0", subkey0); end
    start_schedule(KEY_Z, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (subkey0 !== 48'h0) begin errors++; $display("FAIL zero_subkey[%0d]: got %h expected 0", i, subkey0); end
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL zero_valid[%0d]: got %b expected 1", i, valid0); end
      step();
    end
  endtask

  task automatic test_parity();
    start_schedule(KEY_A, 1'b0);
    checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL par_good_key: got %b expected 0", perr1); end
    for (int i = 0; i < 16; i++) step();
    start_schedule(KEY_BAD, 1'b0);
    checks++; if (perr1 !== 1'b1) begin errors++; $display("FAIL par_bad_key: got %b expected 1", perr1); end
    checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL par_disabled: got %b expected 0", perr0); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (subkey1 !== enc_k[i]) begin errors++; $display("FAIL par_subkey[%0d]: got %h expected %h", i, subkey1, enc_k[i]); end
      step();
    end
    checks++; if (perr1 !== 1'b1) begin errors++; $display("FAIL par_sticky: got %b expected 1", perr1); end
    start_schedule(KEY_Z, 1'b0);
    checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL par_cleared_by_start: got %b expected 0", perr1); end
    for (int i = 0; i < 16; i++) step();
    start_schedule(KEY_BAD, 1'b1);
    checks++; if (perr1 !== 1'b1) begin errors++; $display("FAIL par_bad_dec: got %b expected 1", perr1); end
    checks++; if (subkey1 !== enc_k[15]) begin errors++; $display("FAIL par_dec_first: got %h expected %h", subkey1, enc_k[15]); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL par_cleared_by_reset: got %b expected 0", perr1); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
